block_averaging_2d: RTL
=======================

# block_averaging_2d

Streaming 2-D block-averaging downscaler: consumes a raster-order pixel stream of LARGURA×ALTURA pixels and emits one pixel per FATOR×FATOR block, equal to the block mean. It sits in the ALU image path between the frame source and the output frame buffer. It adds valid/ready handshaking, frame framing and a line accumulator, so it handles true 2-D blocks at any power-of-two factor.

## Interface
- LARGURA, 320, input frame width in pixels; multiple of FATOR
- ALTURA, 240, input frame height in pixels; multiple of FATOR
- FATOR, 2, block edge; one of 1, 2, 4, 8
- PIXEL_W, 8, pixel bit width
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  pixel_in/in_sof valid
- in_ready  out  1  block accepts the input this cycle
- pixel_in  in  PIXEL_W  input pixel
- in_sof  in  1  marks pixel (0,0) of a frame
- out_valid  out  1  output pixel valid
- out_ready  in  1  downstream accepts output
- pixel_out  out  PIXEL_W  block mean
- out_eol  out  1  last block of an output row
- out_eof  out  1  last block of the frame

## Operation
- Accept = in_valid && in_ready. Counters x (0..LARGURA-1), y (0..ALTURA-1) advance on accept only; x wraps to 0 and increments y; y wraps to 0 after last row.
- Accepted in_sof forces that pixel to be (0,0); partial sums discarded, no output for an aborted partial frame.
- Horizontal sum hsum accumulates FATOR pixels; at x%FATOR==FATOR-1, entry bx=x/FATOR of the line buffer is written: hsum if y%FATOR==0, else buf[bx]+hsum.
- At y%FATOR==FATOR-1 and x%FATOR==FATOR-1: total = buf[bx]+hsum (current pixel included); pixel_out = total >> (2·log2 FATOR); loaded into output register with out_eol (bx==LARGURA/FATOR-1) and out_eof (also y==ALTURA-1).
- Sum width SUM_W = PIXEL_W + 2·log2(FATOR); never overflows; result always fits PIXEL_W.
- FATOR==1: pass-through with register, every pixel emitted.
- Reset values: in_ready 1 after reset released, out_valid 0, pixel_out 0, out_eol 0, out_eof 0, x=y=0, hsum 0. Line buffer contents need no reset (first row of each block overwrites).
- Reset mid-frame: all progress lost; next accepted pixel treated as (0,0) regardless of in_sof.

## Timing
- Latency: out_valid asserted the cycle after the accept of a block's last pixel.
- in_ready = !out_valid || out_ready (one-entry output register, combinational ready path).
- While out_valid && !out_ready: pixel_out, out_eol, out_eof held stable; no input accepted.
- Output handshake completes on out_valid && out_ready; a new result may load in that same cycle.
- Line buffer: register array, LARGURA/FATOR entries × SUM_W, asynchronous read, synchronous write; read and write of same bx in one cycle returns old value.

## Configuration
- ROUNDING_EN defined: total + 2^(shift-1) before shift (round half up; skipped when FATOR==1). Undefined: truncation.

## Structure
- Package block_avg_pkg: log2 function, SUM_W and shift constant derivation, legal-FATOR check.
- Sub-module sum_line_buffer: parametrised depth/width register array with the read/write port above.

## Test plan
- LARGURA=4, ALTURA=4, FATOR=2, rows 10 20 30 40 / 50 60 70 80 / 1 1 2 2 / 3 3 4 4 -> outputs 35, 55, 2, 3; out_eol on 55 and 3, out_eof on 3 only.
- Block 0 1 / 1 1: ROUNDING_EN undefined -> 0; defined -> 1. All-255 frame -> every output 255.
- out_ready held low 5 cycles while out_valid -> in_ready low, pixel_out stable, no pixel lost; sequence identical to unstalled run.
- in_sof asserted at pixel (2,1) -> partial frame dropped; next frame results correct from new origin.
- reset asserted mid-frame for one cycle -> out_valid 0 next cycle; following frame averages correct.
- FATOR=4, LARGURA=8, ALTURA=4, pixel value = x -> outputs 1, 5 (truncate), out_eof on second.

Source files
------------

// File: rtl/block_avg_pkg.sv
// Shared helpers for the block-averaging downscaler: factor legality, log2 and
// derivation of accumulator width, averaging shift and rounding bias.
package block_avg_pkg;

  function automatic int unsigned log2_ceil(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic bit fator_legal(input int unsigned f);
    return (f == 1) || (f == 2) || (f == 4) || (f == 8);
  endfunction

  // A FATOR x FATOR block sum needs 2*log2(FATOR) extra bits; dividing by the
  // pixel count is the same shift.
  function automatic int unsigned avg_shift(input int unsigned f);
    return 2 * log2_ceil(f);
  endfunction

  function automatic int unsigned sum_width(input int unsigned pw, input int unsigned f);
    return pw + avg_shift(f);
  endfunction

  function automatic int unsigned round_bias(input int unsigned shift);
    return (shift == 0) ? 0 : (32'd1 << (shift - 1));
  endfunction

endpackage

// File: rtl/sum_line_buffer.sv
// Per-block-column partial-sum store: asynchronous read, synchronous write;
// a same-address read during a write returns the old contents.
module sum_line_buffer #(
  parameter int unsigned DEPTH = 160,
  parameter int unsigned WIDTH = 10,
  parameter int unsigned AW    = 8
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/block_averaging_2d.sv
// Streaming FATOR x FATOR block-mean downscaler with valid/ready framing.
// Define ROUNDING_EN for round-half-up means; default build truncates.
module block_averaging_2d
  import block_avg_pkg::*;
#(
  parameter int unsigned LARGURA = 320,
  parameter int unsigned ALTURA  = 240,
  parameter int unsigned FATOR   = 2,
  parameter int unsigned PIXEL_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PIXEL_W-1:0] pixel_in,
  input  logic               in_sof,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PIXEL_W-1:0] pixel_out,
  output logic               out_eol,
  output logic               out_eof
);

  localparam int unsigned HSH   = log2_ceil(FATOR);
  localparam int unsigned SHIFT = avg_shift(FATOR);
  localparam int unsigned SUM_W = sum_width(PIXEL_W, FATOR);
  localparam int unsigned BLK_W = LARGURA / FATOR;
  localparam int unsigned XW    = (LARGURA > 1) ? $clog2(LARGURA) : 1;
  localparam int unsigned YW    = (ALTURA > 1) ? $clog2(ALTURA) : 1;
  localparam int unsigned AW    = (BLK_W > 1) ? $clog2(BLK_W) : 1;

  localparam logic [XW-1:0] X_LAST  = XW'(LARGURA - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(ALTURA - 1);
  localparam logic [XW-1:0] X_MASK  = XW'(FATOR - 1);
  localparam logic [YW-1:0] Y_MASK  = YW'(FATOR - 1);
  localparam logic [AW-1:0] BX_LAST = AW'(BLK_W - 1);

  if (!fator_legal(FATOR)) begin : g_bad_fator
    $error("block_averaging_2d: FATOR must be 1, 2, 4 or 8");
  end

  logic [XW-1:0]      r_x, w_x;
  logic [YW-1:0]      r_y, w_y;
  logic [SUM_W-1:0]   r_hsum, w_hsum, w_rdata, w_wdata, w_total;
  logic [AW-1:0]      w_bx;
  logic               w_accept, w_xstart, w_xend, w_ystart, w_yend;
  logic [PIXEL_W-1:0] w_mean;
  logic               r_out_valid, r_eol, r_eof;
  logic [PIXEL_W-1:0] r_pixel;

  assign in_ready  = !r_out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_out_valid;
  assign pixel_out = r_pixel;
  assign out_eol   = r_eol;
  assign out_eof   = r_eof;

  // An accepted start-of-frame overrides the running position, so the
  // current pixel itself is treated as (0,0).
  always_comb begin
    w_x      = in_sof ? '0 : r_x;
    w_y      = in_sof ? '0 : r_y;
    w_xstart = (w_x & X_MASK) == '0;
    w_xend   = (w_x & X_MASK) == X_MASK;
    w_ystart = (w_y & Y_MASK) == '0;
    w_yend   = (w_y & Y_MASK) == Y_MASK;
    w_bx     = AW'(w_x >> HSH);
    w_hsum   = w_xstart ? SUM_W'(pixel_in) : r_hsum + SUM_W'(pixel_in);
    // Same value is the buffer update and, on the block's last row, the total.
    w_wdata  = w_ystart ? w_hsum : w_rdata + w_hsum;
`ifdef ROUNDING_EN
    w_total  = w_wdata + SUM_W'(round_bias(SHIFT));
`else
    w_total  = w_wdata;
`endif
    w_mean   = PIXEL_W'(w_total >> SHIFT);
  end

  sum_line_buffer #(
    .DEPTH (BLK_W),
    .WIDTH (SUM_W),
    .AW    (AW)
  ) u_line_buf (
    .clk     (clk),
    .i_we    (w_accept && w_xend),
    .i_waddr (w_bx),
    .i_wdata (w_wdata),
    .i_raddr (w_bx),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_x         <= '0;
      r_y         <= '0;
      r_hsum      <= '0;
      r_out_valid <= 1'b0;
      r_pixel     <= '0;
      r_eol       <= 1'b0;
      r_eof       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_hsum <= w_hsum;
        if (w_x == X_LAST) begin
          r_x <= '0;
          r_y <= (w_y == Y_LAST) ? '0 : w_y + YW'(1);
        end else begin
          r_x <= w_x + XW'(1);
          r_y <= w_y;
        end
      end
      if (w_accept && w_xend && w_yend) begin
        r_out_valid <= 1'b1;
        r_pixel     <= w_mean;
        r_eol       <= (w_bx == BX_LAST);
        r_eof       <= (w_bx == BX_LAST) && (w_y == Y_LAST);
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule
